ldm_window_reader: RTL and testbench
====================================

// Module: ldm_window_reader
// PURPOSE
//  Read-address sequencer directly upstream of the LSU's controller read port A.
//  Walks a KxK convolution window, stride 1, over one W x H feature map held in one
//  LDM bank, emitting CTRL_LDM_addra/ena/wea and Padding_Read.
//  With pad_en, out-of-image taps assert Padding_Read instead of a RAM read.
// PARAMETERS
//  LDM_AD_WIDTH  6   word address bits per LDM bank (64 words)
//  LDM_SRC_BITS  2   bank-select bits prefixed to the address
//  DIM_BITS      4   width of img_w_in / img_h_in
//  K             3   kernel size; padding is (K-1)/2 when pad_en
// PORTS
//  CLK                 in   1                  clock
//  RST                 in   1                  asynchronous reset, active low
//  start_in            in   1                  start pulse; sampled only in IDLE
//  src_bank_in         in   LDM_SRC_BITS       source LDM bank; latched at start
//  img_w_in            in   DIM_BITS           map width W; latched at start
//  img_h_in            in   DIM_BITS           map height H; latched at start
//  pad_en_in           in   1                  enable zero padding P=(K-1)/2; latched at start
//  stall_in            in   1                  hold the sequence this cycle
//  CTRL_LDM_addra_out  out  SRC+AD             {bank, r*W+c}; 0 when not reading
//  CTRL_LDM_ena_out    out  1                  in-image tap read strobe
//  CTRL_LDM_wea_out    out  1                  tied 0; read-only sequencer
//  Padding_Read_out    out  1                  tap is out of image (padding)
//  win_last_out        out  1                  marks the last tap (ky=kx=K-1) of each window
//  busy_out            out  1                  sequence in progress
//  done_out            out  1                  1-cycle pulse after final tap
//  err_out             out  1                  1-cycle pulse when start is rejected
// BEHAVIOUR
//  - All outputs are registered. Async reset sets all outputs to 0 and the FSM to IDLE.
//  - Reset mid-sequence aborts the sequence; no resume is possible.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE:
//    - start at edge N with a legal config: latch config, go to RUN, busy=1 from edge N.
//    - Illegal config is any of: W=0; H=0; W*H > 2^LDM_AD_WIDTH; OW<1; OH<1.
//    - Illegal config: err_out=1 for one cycle; stay in IDLE.
//  - Output dimensions: OW = W+2P-K+1, OH = H+2P-K+1.
//    - Tap order: oy, ox, ky, kx, with kx fastest.
//    - Total taps = OW*OH*K*K.
//  - Tap coordinates: r = oy+ky-P, c = ox+kx-P.
//    - Use signed DIM_BITS+2 arithmetic. The product r*W is truncated to LDM_AD_WIDTH bits.
//  - Tap output:
//    - In image (0<=r<H, 0<=c<W): ena=1, Padding_Read=0, addr={bank, r*W+c}.
//    - Else: ena=0, Padding_Read=1, addr=0.
//  - Latency and rate:
//    - Tap 0 is registered at edge N+1.
//    - One tap per unstalled cycle; no bubbles between windows.
//  - stall_in=1 at an edge:
//    - Counters hold.
//    - The registered ena, Padding_Read and win_last go to 0 for that cycle.
//    - The held tap is re-issued on the first unstalled edge.
//  - After the final tap, go to DONE. At the next edge: done_out=1, busy=0, return to IDLE.
//  - start while busy or in DONE: ignored, no error.
//  - stall and done coincide: stall has priority; done is delayed.
// STRUCTURE
//  - Package cnn_lsu_pkg holds:
//    - LDM_AD_WIDTH, LDM_SRC_BITS and K;
//    - the FSM state encoding (IDLE/RUN/DONE);
//    - the helper function for the padding offset P.
//  - One sub-module, ldm_win_counter: the 4-level nested counter (kx, ky, ox, oy).
//    - Interface: adv, clear, limits; outputs: counts, last_tap, last_win_tap.
//  - The top level holds the FSM, config latch, bound check, address multiply/add,
//    and output registers.
// TESTING
//  1. W=H=4, pad=0, bank=2, start:
//     - 36 taps.
//     - First window addrs 0x80,81,82,84,85,86,88,89,8A; win_last on the 9th tap.
//     - done one cycle after tap 36.
//  2. W=H=3, pad=1, bank=0:
//     - 81 taps.
//     - Window 0 = pad,pad,pad,pad,0x00,0x01,pad,0x03,0x04.
//     - Final tap is pad.
//  3. Case 1 with stall_in=1 for 3 cycles after tap 4:
//     - ena=0 for 3 cycles, then tap 5 = 0x85; done delayed by exactly 3 cycles.
//  4. W=9, H=8 (72>64), start:
//     - err_out pulses once; busy stays 0; no ena.
//     - A legal start afterwards behaves as case 1.
//  5. RST low during tap 20 of case 1:
//     - All outputs 0 asynchronously.
//     - A re-start restarts at tap 0 (addr 0x80).
//  6. start pulsed while busy in case 1:
//     - Ignored; the tap sequence and the 36-tap count are unchanged.

Source files
------------

// File: rtl/cnn_lsu_pkg.sv
// rtl/cnn_lsu_pkg.sv - shared LDM geometry, kernel size and window-reader state encoding
package cnn_lsu_pkg;

  localparam int LDM_AD_WIDTH = 6;
  localparam int LDM_SRC_BITS = 2;
  localparam int DIM_BITS     = 4;
  localparam int K            = 3;

  localparam int K_BITS    = (K > 1) ? $clog2(K) : 1;
  localparam int SDIM_BITS = DIM_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  // Zero-padding border width for a KxK stride-1 window.
  function automatic logic [SDIM_BITS-1:0] pad_offset(input logic pad_en);
    return pad_en ? SDIM_BITS'((K - 1) / 2) : '0;
  endfunction

endpackage

// File: rtl/ldm_win_counter.sv
// rtl/ldm_win_counter.sv - nested kx/ky/ox/oy tap counter, kx fastest
module ldm_win_counter
  import cnn_lsu_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                adv,
  input  logic [DIM_BITS-1:0] ox_last,
  input  logic [DIM_BITS-1:0] oy_last,
  output logic [K_BITS-1:0]   kx,
  output logic [K_BITS-1:0]   ky,
  output logic [DIM_BITS-1:0] ox,
  output logic [DIM_BITS-1:0] oy,
  output logic                last_tap,
  output logic                last_win_tap
);

  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(K - 1);

  logic kx_end, ky_end, ox_end, oy_end;

  assign kx_end       = (kx == K_LAST);
  assign ky_end       = (ky == K_LAST);
  assign ox_end       = (ox == ox_last);
  assign oy_end       = (oy == oy_last);
  assign last_win_tap = kx_end && ky_end;
  assign last_tap     = last_win_tap && ox_end && oy_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clear) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (adv) begin
      kx <= kx_end ? '0 : kx + 1'b1;
      if (kx_end) begin
        ky <= ky_end ? '0 : ky + 1'b1;
        if (ky_end) begin
          ox <= ox_end ? '0 : ox + 1'b1;
          if (ox_end) begin
            oy <= oy_end ? '0 : oy + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ldm_window_reader.sv
// rtl/ldm_window_reader.sv - KxK stride-1 window read-address sequencer for LDM port A
module ldm_window_reader
  import cnn_lsu_pkg::*;
(
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 start_in,
  input  logic [LDM_SRC_BITS-1:0]              src_bank_in,
  input  logic [DIM_BITS-1:0]                  img_w_in,
  input  logic [DIM_BITS-1:0]                  img_h_in,
  input  logic                                 pad_en_in,
  input  logic                                 stall_in,
  output logic [LDM_SRC_BITS+LDM_AD_WIDTH-1:0] CTRL_LDM_addra_out,
  output logic                                 CTRL_LDM_ena_out,
  output logic                                 CTRL_LDM_wea_out,
  output logic                                 Padding_Read_out,
  output logic                                 win_last_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 err_out
);

  localparam int ADDR_W = LDM_SRC_BITS + LDM_AD_WIDTH;
  localparam int AREA_W = 2 * DIM_BITS;
  localparam logic [AREA_W-1:0]           AREA_MAX = AREA_W'(1 << LDM_AD_WIDTH);
  localparam logic signed [SDIM_BITS-1:0] S_ZERO   = '0;
  localparam logic signed [SDIM_BITS-1:0] S_ONE    = SDIM_BITS'(1);
  localparam logic signed [SDIM_BITS-1:0] S_KM1    = SDIM_BITS'(K - 1);

  rd_state_e state_q, state_d;

  // Start-time legality check, evaluated directly on the unlatched inputs.
  logic [SDIM_BITS-1:0]        p_in;
  logic signed [SDIM_BITS-1:0] ow_in, oh_in;
  logic [AREA_W-1:0]           area_in;
  logic                        cfg_legal, start_ok;

  assign p_in    = pad_offset(pad_en_in);
  assign ow_in   = $signed({2'b00, img_w_in}) + $signed(p_in) + $signed(p_in) - S_KM1;
  assign oh_in   = $signed({2'b00, img_h_in}) + $signed(p_in) + $signed(p_in) - S_KM1;
  assign area_in = {{DIM_BITS{1'b0}}, img_w_in} * {{DIM_BITS{1'b0}}, img_h_in};
  assign cfg_legal = (|img_w_in) && (|img_h_in) && (area_in <= AREA_MAX)
                     && (ow_in > S_ZERO) && (oh_in > S_ZERO);
  assign start_ok  = (state_q == ST_IDLE) && start_in && cfg_legal;

  logic [LDM_SRC_BITS-1:0] bank_q;
  logic [DIM_BITS-1:0]     w_q, h_q, ox_last_q, oy_last_q;
  logic [SDIM_BITS-1:0]    p_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bank_q    <= '0;
      w_q       <= '0;
      h_q       <= '0;
      p_q       <= '0;
      ox_last_q <= '0;
      oy_last_q <= '0;
    end else if (start_ok) begin
      bank_q    <= src_bank_in;
      w_q       <= img_w_in;
      h_q       <= img_h_in;
      p_q       <= p_in;
      ox_last_q <= DIM_BITS'(ow_in - S_ONE);
      oy_last_q <= DIM_BITS'(oh_in - S_ONE);
    end
  end

  logic                cnt_clear, cnt_adv, last_tap, last_win_tap;
  logic [K_BITS-1:0]   kx, ky;
  logic [DIM_BITS-1:0] ox, oy;

  ldm_win_counter u_cnt (
    .CLK          (CLK),
    .RST          (RST),
    .clear        (cnt_clear),
    .adv          (cnt_adv),
    .ox_last      (ox_last_q),
    .oy_last      (oy_last_q),
    .kx           (kx),
    .ky           (ky),
    .ox           (ox),
    .oy           (oy),
    .last_tap     (last_tap),
    .last_win_tap (last_win_tap)
  );

  // Tap coordinates in image space; negative or beyond W/H means padding.
  logic signed [SDIM_BITS-1:0] r_s, c_s;
  logic                        in_img;
  logic [LDM_AD_WIDTH-1:0]     r_ad, w_ad, c_ad, lin_addr;

  assign r_s = $signed({2'b00, oy}) + $signed({{(SDIM_BITS-K_BITS){1'b0}}, ky}) - $signed(p_q);
  assign c_s = $signed({2'b00, ox}) + $signed({{(SDIM_BITS-K_BITS){1'b0}}, kx}) - $signed(p_q);
  assign in_img = (r_s >= S_ZERO) && (c_s >= S_ZERO)
                  && (r_s < $signed({2'b00, h_q})) && (c_s < $signed({2'b00, w_q}));
  assign r_ad     = LDM_AD_WIDTH'($unsigned(r_s));
  assign c_ad     = LDM_AD_WIDTH'($unsigned(c_s));
  assign w_ad     = LDM_AD_WIDTH'(w_q);
  assign lin_addr = r_ad * w_ad + c_ad;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_in && cfg_legal) state_d = ST_RUN;
      ST_RUN:  if (!stall_in && last_tap) state_d = ST_DONE;
      ST_DONE: if (!stall_in)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  logic [ADDR_W-1:0] addr_d;
  logic              ena_d, pad_d, wl_d, busy_d, done_d, err_d;

  always_comb begin
    addr_d    = '0;
    ena_d     = 1'b0;
    pad_d     = 1'b0;
    wl_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        busy_d    = start_in && cfg_legal;
        err_d     = start_in && !cfg_legal;
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (!stall_in) begin
          cnt_adv = 1'b1;
          ena_d   = in_img;
          pad_d   = !in_img;
          wl_d    = last_win_tap;
          addr_d  = in_img ? {bank_q, lin_addr} : '0;
        end
      end
      ST_DONE: begin
        busy_d = stall_in;
        done_d = !stall_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CTRL_LDM_addra_out <= '0;
      CTRL_LDM_ena_out   <= 1'b0;
      Padding_Read_out   <= 1'b0;
      win_last_out       <= 1'b0;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
      err_out            <= 1'b0;
    end else begin
      CTRL_LDM_addra_out <= addr_d;
      CTRL_LDM_ena_out   <= ena_d;
      Padding_Read_out   <= pad_d;
      win_last_out       <= wl_d;
      busy_out           <= busy_d;
      done_out           <= done_d;
      err_out            <= err_d;
    end
  end

  assign CTRL_LDM_wea_out = 1'b0;

endmodule

// File: tb/tb_ldm_window_reader.sv
// tb/tb_ldm_window_reader.sv - directed bench for the LDM window read sequencer
module tb_ldm_window_reader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start_in = 1'b0;
  logic [1:0] src_bank_in = '0;
  logic [3:0] img_w_in = '0;
  logic [3:0] img_h_in = '0;
  logic       pad_en_in = 1'b0;
  logic       stall_in = 1'b0;
  logic [7:0] CTRL_LDM_addra_out;
  logic       CTRL_LDM_ena_out, CTRL_LDM_wea_out, Padding_Read_out;
  logic       win_last_out, busy_out, done_out, err_out;

  ldm_window_reader dut (
    .CLK                (CLK),
    .RST                (RST),
    .start_in           (start_in),
    .src_bank_in        (src_bank_in),
    .img_w_in           (img_w_in),
    .img_h_in           (img_h_in),
    .pad_en_in          (pad_en_in),
    .stall_in           (stall_in),
    .CTRL_LDM_addra_out (CTRL_LDM_addra_out),
    .CTRL_LDM_ena_out   (CTRL_LDM_ena_out),
    .CTRL_LDM_wea_out   (CTRL_LDM_wea_out),
    .Padding_Read_out   (Padding_Read_out),
    .win_last_out       (win_last_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .err_out            (err_out)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int tap_val [0:255];
  int n_taps, first_cyc, done_cyc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {win_last, pad, ena, addr[7:0]}
  function automatic int snap();
    return int'({win_last_out, Padding_Read_out, CTRL_LDM_ena_out, CTRL_LDM_addra_out});
  endfunction

  task automatic do_start(input int bank, input int w, input int h, input int pad, input int legal);
    @(negedge CLK);
    src_bank_in = 2'(bank);
    img_w_in    = 4'(w);
    img_h_in    = 4'(h);
    pad_en_in   = (pad != 0);
    start_in    = 1'b1;
    @(negedge CLK);
    start_in = 1'b0;
    check_eq("start_busy", int'(busy_out), legal);
    check_eq("start_err", int'(err_out), (legal != 0) ? 0 : 1);
  endtask

  task automatic capture(input int stall_after, input int stall_len, input int pulse_at, input int abort_at);
    int stalled = 0;
    bit prev_stall = 1'b0;
    bit stall_now;
    n_taps = 0; first_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      if (prev_stall) check_eq("stall_gap", snap(), 0);
      if (CTRL_LDM_ena_out || Padding_Read_out) begin
        if (n_taps < 256) tap_val[n_taps] = snap();
        if (first_cyc < 0) first_cyc = i;
        n_taps++;
      end
      if (done_out) begin
        done_cyc = i;
        break;
      end
      if (abort_at > 0 && n_taps == abort_at) break;
      stall_now = (stall_len > 0) && (n_taps >= stall_after) && (stalled < stall_len);
      if (stall_now) stalled++;
      stall_in   = stall_now;
      prev_stall = stall_now;
      start_in   = (i == pulse_at);
      if (i == pulse_at) begin
        img_w_in    = 4'd3;
        src_bank_in = 2'd0;
      end
      @(negedge CLK);
    end
    stall_in = 1'b0;
    start_in = 1'b0;
    if (abort_at == 0) begin
      check_eq("done_seen", int'(done_cyc >= 0), 1);
      if (done_cyc >= 0) begin
        check_eq("done_gap", done_cyc - first_cyc, n_taps + stall_len);
        @(negedge CLK);
        check_eq("done_pulse", int'({done_out, busy_out}), 0);
      end
    end
  endtask

  task automatic check_seq(input int w, input int h, input int pad, input int bank);
    int p, ow, oh, idx, r, c, e;
    bit inimg, wl;
    p = (pad != 0) ? 1 : 0;
    ow = w + 2 * p - 2;
    oh = h + 2 * p - 2;
    idx = 0;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            r = oy + ky - p;
            c = ox + kx - p;
            inimg = (r >= 0) && (r < h) && (c >= 0) && (c < w);
            wl = (ky == 2) && (kx == 2);
            e = (int'(wl) << 10) | (int'(!inimg) << 9) | (int'(inimg) << 8)
                | (inimg ? ((bank << 6) | (r * w + c)) : 0);
            if (idx < n_taps && idx < 256) check_eq($sformatf("tap%0d", idx), tap_val[idx], e);
            idx++;
          end
    check_eq("ntaps", n_taps, ow * oh * 9);
  endtask

  int c1_win0 [9] = '{'h80, 'h81, 'h82, 'h84, 'h85, 'h86, 'h88, 'h89, 'h8A};
  int c2_win0 [9] = '{'h200, 'h200, 'h200, 'h200, 'h100, 'h101, 'h200, 'h103, 'h504};
  int acc;

  initial begin
    repeat (3) @(negedge CLK);
    check_eq("rst_outs", int'({CTRL_LDM_addra_out, CTRL_LDM_ena_out, CTRL_LDM_wea_out,
                              Padding_Read_out, win_last_out, busy_out, done_out, err_out}), 0);
    RST = 1'b1;

    // 1: 4x4, no padding, bank 2
    do_start(2, 4, 4, 0, 1);
    capture(0, 0, -1, 0);
    check_seq(4, 4, 0, 2);
    for (int i = 0; i < 9; i++) check_eq($sformatf("c1_addr%0d", i), tap_val[i] & 'hFF, c1_win0[i]);
    check_eq("c1_wl_tap9", (tap_val[8] >> 10) & 1, 1);
    check_eq("c1_wl_tap8", (tap_val[7] >> 10) & 1, 0);

    // 2: 3x3, padded, bank 0
    do_start(0, 3, 3, 1, 1);
    capture(0, 0, -1, 0);
    check_seq(3, 3, 1, 0);
    for (int i = 0; i < 9; i++) check_eq($sformatf("c2_win0_%0d", i), tap_val[i], c2_win0[i]);
    check_eq("c2_final_pad", tap_val[80], 'h600);

    // 3: stall 3 cycles after tap 4
    do_start(2, 4, 4, 0, 1);
    capture(4, 3, -1, 0);
    check_seq(4, 4, 0, 2);
    check_eq("c3_tap5", tap_val[4], 'h185);

    // 4: oversized map rejected, then a legal start
    do_start(2, 9, 8, 0, 0);
    acc = 0;
    repeat (5) begin
      @(negedge CLK);
      acc += int'(CTRL_LDM_ena_out) + int'(busy_out) + int'(err_out);
    end
    check_eq("c4_quiet", acc, 0);
    do_start(2, 4, 4, 0, 1);
    capture(0, 0, -1, 0);
    check_seq(4, 4, 0, 2);

    // 5: async reset during tap 20, then restart
    do_start(2, 4, 4, 0, 1);
    capture(0, 0, -1, 20);
    check_eq("c5_taps_before_rst", n_taps, 20);
    #2 RST = 1'b0;
    #1 check_eq("c5_async_clear", int'({CTRL_LDM_addra_out, CTRL_LDM_ena_out, Padding_Read_out,
                                       win_last_out, busy_out, done_out}), 0);
    @(negedge CLK);
    RST = 1'b1;
    do_start(2, 4, 4, 0, 1);
    capture(0, 0, -1, 0);
    check_seq(4, 4, 0, 2);
    check_eq("c5_restart_tap0", tap_val[0], 'h180);

    // 6: start pulse while busy is ignored
    do_start(2, 4, 4, 0, 1);
    capture(0, 0, 10, 0);
    check_seq(4, 4, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
